// File: rtl/card_shoe.sv
// card_shoe: single-deck card shoe for the game controller.
//
// Holds 52 cards in an internal RAM, optionally shuffles them in place
// (Fisher-Yates driven by a free-running 16-bit Galois LFSR) and deals one
// card per accepted draw. At a round boundary the deck is refilled (and
// reshuffled) once the number of undealt cards has dropped low enough.
//
// Optional feature macro: CARD_SHOE_SHUFFLE_EN
//   defined   : LFSR + SHUFFLE phase compiled in.
//   undefined : no LFSR/SHUFFLE; deck is dealt in fill order 6'h01..6'h3D.
//
// Ports:
//   i_clk        clock, all state on rising edge
//   i_reset      asynchronous, active-high reset
//   i_draw       draw request, one card per cycle while o_ready
//   i_new_round  1-cycle round-start pulse, may trigger a refill/reshuffle
//   o_card       dealt card {suit[1:0], rank[3:0]}, rank 1..13
//   o_card_valid 1-cycle strobe qualifying o_card
//   o_ready      deck prepared, draws accepted
//   o_cards_left undealt cards 0..52 (0 while not ready)
//   o_empty      deck exhausted while ready
module card_shoe #(
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int unsigned RESHUFFLE_AT = 12
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_draw,
  input  logic       i_new_round,
  output logic [5:0] o_card,
  output logic       o_card_valid,
  output logic       o_ready,
  output logic [5:0] o_cards_left,
  output logic       o_empty
);

  localparam logic [5:0] DECK_SIZE = 6'd52;
  localparam logic [5:0] LAST_IDX  = 6'd51;
  localparam logic [5:0] RESHUF    = 6'(RESHUFFLE_AT);

  typedef enum logic [2:0] {
    S_INIT,
    S_PICK,
    S_SWAP_RD,
    S_SWAP_WR,
    S_READY
  } state_t;

  state_t     state;
  logic [5:0] fill_k;
  logic [1:0] suit;
  logic [3:0] rank;
  logic [5:0] ptr;
  logic [5:0] card_q;
  logic       valid_q;
  logic       ready_q;

  logic [5:0] mem [0:51];

  logic       we_a, we_b;
  logic [5:0] addr_a, addr_b;
  logic [5:0] data_a, data_b;

`ifdef CARD_SHOE_SHUFFLE_EN
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  logic [15:0] lfsr;
  logic [5:0]  idx_i, idx_j;
  logic [5:0]  hold_i, hold_j;
`endif

  // Two write ports: INIT uses port A only; a swap writes both halves at once.
  always_comb begin
    we_a   = 1'b0;
    addr_a = '0;
    data_a = '0;
    we_b   = 1'b0;
    addr_b = '0;
    data_b = '0;
    if (state == S_INIT) begin
      we_a   = 1'b1;
      addr_a = fill_k;
      data_a = {suit, rank};
    end
`ifdef CARD_SHOE_SHUFFLE_EN
    else if (state == S_SWAP_WR) begin
      we_a   = 1'b1;
      addr_a = idx_i;
      data_a = hold_j;
      we_b   = 1'b1;
      addr_b = idx_j;
      data_b = hold_i;
    end
`endif
  end

  // When idx_i == idx_j both ports carry the same value, so order is moot.
  always_ff @(posedge i_clk) begin
    if (we_a) mem[addr_a] <= data_a;
    if (we_b) mem[addr_b] <= data_b;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= S_INIT;
      fill_k  <= '0;
      suit    <= '0;
      rank    <= 4'd1;
      ptr     <= '0;
      card_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
`ifdef CARD_SHOE_SHUFFLE_EN
      lfsr    <= SEED_EFF;
      idx_i   <= LAST_IDX;
      idx_j   <= '0;
      hold_i  <= '0;
      hold_j  <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
`ifdef CARD_SHOE_SHUFFLE_EN
      lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
`endif
      case (state)
        S_INIT: begin
          fill_k <= fill_k + 6'd1;
          if (rank == 4'd13) begin
            rank <= 4'd1;
            suit <= suit + 2'd1;
          end else begin
            rank <= rank + 4'd1;
          end
          if (fill_k == LAST_IDX) begin
            fill_k <= '0;
`ifdef CARD_SHOE_SHUFFLE_EN
            idx_i  <= LAST_IDX;
            state  <= S_PICK;
`else
            ptr     <= '0;
            ready_q <= 1'b1;
            state   <= S_READY;
`endif
          end
        end
`ifdef CARD_SHOE_SHUFFLE_EN
        S_PICK: begin
          // Rejection sampling keeps j uniform over 0..i.
          if (lfsr[5:0] <= idx_i) begin
            idx_j <= lfsr[5:0];
            state <= S_SWAP_RD;
          end
        end
        S_SWAP_RD: begin
          hold_i <= mem[idx_i];
          hold_j <= mem[idx_j];
          state  <= S_SWAP_WR;
        end
        S_SWAP_WR: begin
          if (idx_i == 6'd1) begin
            ptr     <= '0;
            ready_q <= 1'b1;
            state   <= S_READY;
          end else begin
            idx_i <= idx_i - 6'd1;
            state <= S_PICK;
          end
        end
`endif
        S_READY: begin
          // A draw in the same cycle always wins over a round pulse.
          if (i_draw) begin
            if (ptr < DECK_SIZE) begin
              card_q  <= mem[ptr];
              valid_q <= 1'b1;
              ptr     <= ptr + 6'd1;
            end
          end else if (i_new_round && (o_cards_left <= RESHUF)) begin
            ready_q <= 1'b0;
            fill_k  <= '0;
            suit    <= '0;
            rank    <= 4'd1;
            state   <= S_INIT;
          end
        end
        default: begin
          ready_q <= 1'b0;
          state   <= S_INIT;
        end
      endcase
    end
  end

  assign o_card       = card_q;
  assign o_card_valid = valid_q;
  assign o_ready      = ready_q;
  assign o_cards_left = ready_q ? (DECK_SIZE - ptr) : '0;
  assign o_empty      = ready_q && (ptr == DECK_SIZE);

endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe: scoreboard bench for card_shoe.
// Stimulus pushes expected cards into a queue; a monitor pops and compares on
// every o_card_valid strobe. With CARD_SHOE_SHUFFLE_EN the deal order is not
// predictable, so the bench checks permutation validity and repeatability.
module tb_card_shoe;
  logic       clk = 1'b0;
  logic       reset;
  logic       draw;
  logic       new_round;
  logic [5:0] card;
  logic       card_valid;
  logic       ready;
  logic [5:0] cards_left;
  logic       empty;

  int checks   = 0;
  int failures = 0;
  int strobes  = 0;
  logic [5:0] exp_q[$];
  logic [5:0] log_q[$];

  always #5 clk = ~clk;

  card_shoe #(.LFSR_SEED(16'hACE1), .RESHUFFLE_AT(12)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_draw       (draw),
    .i_new_round  (new_round),
    .o_card       (card),
    .o_card_valid (card_valid),
    .o_ready      (ready),
    .o_cards_left (cards_left),
    .o_empty      (empty)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [5:0] fill_code(input int k);
    logic [1:0] s;
    logic [3:0] r;
    s = 2'(k / 13);
    r = 4'(k % 13 + 1);
    return {s, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 30000) begin
      tick();
      n++;
    end
  endtask

  // Hold draw for count cycles; expected cards are fill-order positions.
  task automatic draw_n(input int count, input int first_k, input bit push);
    draw = 1'b1;
    for (int i = 0; i < count; i++) begin
      if (push) exp_q.push_back(fill_code(first_k + i));
      tick();
    end
    draw = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && card_valid === 1'b1) begin
      strobes++;
      log_q.push_back(card);
`ifndef CARD_SHOE_SHUFFLE_EN
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got card 0x%0h expected no strobe", card);
      end else begin
        check("card", card, exp_q.pop_front());
      end
`endif
    end
  end

  initial begin
    int n;
    int s;
    draw      = 1'b0;
    new_round = 1'b0;
    reset     = 1'b1;
    repeat (3) tick();
    check("rst_ready", ready, 0);
    check("rst_valid", card_valid, 0);
    check("rst_left", cards_left, 0);
    check("rst_empty", empty, 0);
    check("rst_card", card, 0);
    reset = 1'b0;

`ifndef CARD_SHOE_SHUFFLE_EN
    wait_ready(n);
    check("init_cycles", n, 52);
    check("left_full", cards_left, 52);
    check("empty_full", empty, 0);

    log_q.delete();
    draw_n(1, 0, 1'b1);
    check("left_after_one", cards_left, 51);
    tick();
    check("strobe_one_cycle", card_valid, 0);
    check("card_hold", card, 6'h01);

    draw_n(51, 1, 1'b1);
    tick();
    check("deal_count", log_q.size(), 52);
    check("card_14", log_q[13], 6'h11);
    check("card_52", log_q[51], 6'h3D);
    check("empty_set", empty, 1);
    check("left_zero", cards_left, 0);
    s = strobes;
    draw = 1'b1;
    tick();
    draw = 1'b0;
    tick();
    check("no_strobe_empty", strobes, s);
    check("no_wrap", cards_left, 0);

    new_round = 1'b1;
    tick();
    new_round = 1'b0;
    check("ready_fall", ready, 0);
    wait_ready(n);
    check("reinit_cycles", n, 52);
    check("left_refill", cards_left, 52);

    draw_n(39, 0, 1'b1);
    check("left_13", cards_left, 13);
    new_round = 1'b1;
    tick();
    new_round = 1'b0;
    tick();
    check("no_reshuffle_13", ready, 1);
    check("left_still_13", cards_left, 13);

    draw_n(1, 39, 1'b1);
    new_round = 1'b1;
    tick();
    new_round = 1'b0;
    check("ready_fall_12", ready, 0);
    wait_ready(n);
    check("reshuffle_cycles", n, 52);
    draw_n(1, 0, 1'b1);
    tick();
    check("first_after_refill", card, 6'h01);

    draw_n(46, 1, 1'b1);
    check("left_5", cards_left, 5);
    draw = 1'b1;
    new_round = 1'b1;
    exp_q.push_back(fill_code(47));
    tick();
    draw = 1'b0;
    new_round = 1'b0;
    check("simul_left", cards_left, 4);
    check("simul_ready", ready, 1);
    tick();
    check("simul_ready_held", ready, 1);

    #2 reset = 1'b1;
    #1;
    check("async_rst_ready", ready, 0);
    check("async_rst_left", cards_left, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_ready(n);
    check("rst_reinit_cycles", n, 52);
    draw_n(1, 0, 1'b1);
    tick();
    check("first_after_rst", card, 6'h01);
    tick();
    check("queue_drained", exp_q.size(), 0);
`else
    begin
      logic [5:0] first_order[$];
      int cnt[64];
      int bad;
      for (int pass = 0; pass < 2; pass++) begin
        wait_ready(n);
        check("shuffle_ready_bound", n < 30000, 1);
        check("left_full", cards_left, 52);
        log_q.delete();
        draw_n(52, 0, 1'b0);
        tick();
        check("deal_count", log_q.size(), 52);
        check("empty_set", empty, 1);
        for (int c = 0; c < 64; c++) cnt[c] = 0;
        bad = 0;
        foreach (log_q[k]) begin
          logic [5:0] c6;
          c6 = log_q[k];
          cnt[c6]++;
          if (c6[3:0] == 4'd0 || c6[3:0] > 4'd13) bad++;
        end
        for (int c = 0; c < 64; c++) begin
          logic [5:0] c6;
          c6 = 6'(c);
          if (c6[3:0] >= 4'd1 && c6[3:0] <= 4'd13 && cnt[c] != 1) bad++;
        end
        check("permutation", bad, 0);
        if (pass == 0) begin
          first_order = log_q;
          reset = 1'b1;
          repeat (3) tick();
          reset = 1'b0;
          repeat (100) tick();
          #2 reset = 1'b1;
          #1;
          check("mid_shuffle_ready", ready, 0);
          check("mid_shuffle_valid", card_valid, 0);
          repeat (3) tick();
          reset = 1'b0;
        end else begin
          bad = 0;
          foreach (log_q[k]) if (log_q[k] !== first_order[k]) bad++;
          check("repeatable_order", bad, 0);
        end
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
